reg_file_swap: RTL and testbench

- Parametrised successor to the 4x8 scratch register file.
- Generalised width and depth, with an asynchronous active-low reset to a programmable value.
- Optional write-to-read bypass.
- Hardware two-cycle register swap, sequenced by a small FSM with busy and dropped-write signalling.
- Sits in the datapath between the ALU/load result mux and the operand read ports, with register 0 exported as the accumulator tap.

---
 rtl/reg_file_swap.sv | 101 ++++++++++
 tb/tb_reg_file_swap.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_swap.sv
// Parametrised register file with optional write-to-read bypass and a
// two-cycle hardware register swap; register 0 is exported as the accumulator tap.
module reg_file_swap #(
    parameter int          W         = 8,
    parameter int          DEPTH     = 4,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  dat_in,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [W-1:0]  datA_out,
    output logic [W-1:0]  datB_out,
    output logic [W-1:0]  dat0_out,
    input  logic          swap_req,
    input  logic [AW-1:0] swap_addrA,
    input  logic [AW-1:0] swap_addrB,
    output logic          busy,
    output logic          wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_t;

    state_t          state_q;
    logic [W-1:0]    core_q [DEPTH];
    logic [W-1:0]    core_d [DEPTH];
    logic [W-1:0]    temp_q;
    logic [W-1:0]    temp_d;
    logic [AW-1:0]   addrb_q;
    logic [AW-1:0]   addrb_d;
    logic            in_swap2;
    logic            wr_take;

    assign in_swap2 = (state_q == SWAP2);
    assign busy     = in_swap2;

    // A swap request in IDLE or any SWAP2 cycle takes the register port away from the write.
    assign wr_drop  = wr_en & rst_n & (in_swap2 | swap_req);
    assign wr_take  = wr_en & rst_n & ~in_swap2 & ~swap_req;

    always_comb begin
        core_d  = core_q;
        temp_d  = temp_q;
        addrb_d = addrb_q;
        if (in_swap2) begin
            core_d[addrb_q] = temp_q;
        end else if (swap_req) begin
            temp_d             = core_q[swap_addrA];
            core_d[swap_addrA] = core_q[swap_addrB];
            addrb_d            = swap_addrB;
        end else if (wr_en) begin
            core_d[wr_addr] = dat_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            temp_q  <= '0;
            addrb_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                core_q[i] <= RESET_VAL;
            end
        end else begin
            core_q  <= core_d;
            temp_q  <= temp_d;
            addrb_q <= addrb_d;
            case (state_q)
                IDLE:    if (swap_req) state_q <= SWAP2;
                SWAP2:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bypass forwards only writes that will actually land at the coming edge.
    always_comb begin
        datA_out = core_q[rd_addrA];
        if (BYPASS && wr_take && (rd_addrA == wr_addr)) begin
            datA_out = dat_in;
        end
    end

    always_comb begin
        datB_out = core_q[rd_addrB];
        if (BYPASS && wr_take && (rd_addrB == wr_addr)) begin
            datB_out = dat_in;
        end
    end

    assign dat0_out = core_q[0];

endmodule

// File: tb/tb_reg_file_swap.sv
// Bench for reg_file_swap: three builds (8b bypass, 8b no-bypass, 16x16 bypass)
// share one stimulus stream and are compared against per-build array models.
module tb_reg_file_swap;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        swap_req;
    logic [3:0]  wa, ra, rb, sa, sb;
    logic [15:0] din;

    logic [7:0]  a_b, b_b, z_b, a_n, b_n, z_n;
    logic [15:0] a_w, b_w, z_w;
    logic        busy_b, drop_b, busy_n, drop_n, busy_w, drop_w;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem  [3][16];
    bit          pend [3];
    logic [3:0]  pb   [3];
    logic [15:0] pv   [3];

    reg_file_swap #(.W(8), .DEPTH(4), .RESET_VAL(8'hA5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa[1:0]), .dat_in(din[7:0]),
        .rd_addrA(ra[1:0]), .rd_addrB(rb[1:0]), .datA_out(a_b), .datB_out(b_b),
        .dat0_out(z_b), .swap_req(swap_req), .swap_addrA(sa[1:0]), .swap_addrB(sb[1:0]),
        .busy(busy_b), .wr_drop(drop_b));

    reg_file_swap #(.W(8), .DEPTH(4), .RESET_VAL(8'hA5), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa[1:0]), .dat_in(din[7:0]),
        .rd_addrA(ra[1:0]), .rd_addrB(rb[1:0]), .datA_out(a_n), .datB_out(b_n),
        .dat0_out(z_n), .swap_req(swap_req), .swap_addrA(sa[1:0]), .swap_addrB(sb[1:0]),
        .busy(busy_n), .wr_drop(drop_n));

    reg_file_swap #(.W(16), .DEPTH(16), .RESET_VAL(16'hBEEF), .BYPASS(1'b1)) u_wide (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa), .dat_in(din),
        .rd_addrA(ra), .rd_addrB(rb), .datA_out(a_w), .datB_out(b_w),
        .dat0_out(z_w), .swap_req(swap_req), .swap_addrA(sa), .swap_addrB(sb),
        .busy(busy_w), .wr_drop(drop_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] wmask(input int c);
        return (c == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [3:0] amask(input int c);
        return (c == 2) ? 4'hF : 4'h3;
    endfunction

    function automatic logic [15:0] rval(input int c);
        return (c == 2) ? 16'hBEEF : 16'h00A5;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 16; i++) mem[c][i] = rval(c);
            pend[c] = 1'b0;
            pb[c]   = '0;
            pv[c]   = '0;
        end
    endtask

    task automatic model_step();
        if (!rst_n) return;
        for (int c = 0; c < 3; c++) begin
            logic [3:0] m;
            m = amask(c);
            if (pend[c]) begin
                mem[c][pb[c]] = pv[c];
                pend[c] = 1'b0;
            end else if (swap_req) begin
                pv[c] = mem[c][sa & m];
                mem[c][sa & m] = mem[c][sb & m];
                pb[c] = sb & m;
                pend[c] = 1'b1;
            end else if (wr_en) begin
                mem[c][wa & m] = din & wmask(c);
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            logic [3:0]  m;
            logic [15:0] ea, eb, ga, gb, gz;
            logic        take, edrop, gbusy, gdrop;
            m     = amask(c);
            edrop = wr_en & rst_n & (pend[c] | swap_req);
            take  = wr_en & rst_n & !pend[c] & !swap_req;
            ea = mem[c][ra & m];
            eb = mem[c][rb & m];
            if (c != 1 && take && ((ra & m) == (wa & m))) ea = din & wmask(c);
            if (c != 1 && take && ((rb & m) == (wa & m))) eb = din & wmask(c);
            case (c)
                0: begin ga = {8'h0, a_b}; gb = {8'h0, b_b}; gz = {8'h0, z_b}; gbusy = busy_b; gdrop = drop_b; end
                1: begin ga = {8'h0, a_n}; gb = {8'h0, b_n}; gz = {8'h0, z_n}; gbusy = busy_n; gdrop = drop_n; end
                default: begin ga = a_w; gb = b_w; gz = z_w; gbusy = busy_w; gdrop = drop_w; end
            endcase
            check_eq($sformatf("c%0d datA", c), ga, ea);
            check_eq($sformatf("c%0d datB", c), gb, eb);
            check_eq($sformatf("c%0d dat0", c), gz, mem[c][0]);
            check_eq($sformatf("c%0d busy", c), {15'h0, gbusy}, {15'h0, pend[c]});
            check_eq($sformatf("c%0d wr_drop", c), {15'h0, gdrop}, {15'h0, edrop});
        end
    endtask

    task automatic drive_chk(input bit we_i, input logic [3:0] wa_i, input logic [15:0] d_i,
                             input logic [3:0] ra_i, input logic [3:0] rb_i,
                             input bit sr_i, input logic [3:0] sa_i, input logic [3:0] sb_i);
        @(negedge clk);
        wr_en = we_i; wa = wa_i; din = d_i; ra = ra_i; rb = rb_i;
        swap_req = sr_i; sa = sa_i; sb = sb_i;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic cyc(input bit we_i, input logic [3:0] wa_i, input logic [15:0] d_i,
                       input logic [3:0] ra_i, input logic [3:0] rb_i,
                       input bit sr_i, input logic [3:0] sa_i, input logic [3:0] sb_i);
        drive_chk(we_i, wa_i, d_i, ra_i, rb_i, sr_i, sa_i, sb_i);
        tick();
    endtask

    // Called just after a negedge check; drops rst_n well before the next rising edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b0;
        rst_n = 1'b1;
        #1;
        check_all();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        wa = '0; ra = '0; rb = '0; sa = '0; sb = '0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset contents visible on every read address.
        for (int i = 0; i < 16; i++) begin
            drive_chk(1'b0, 4'h0, 16'h0, 4'(i), 4'(15 - i), 1'b0, 4'h0, 4'h0);
            check_eq("t1 datA", {8'h0, a_b}, 16'h00A5);
            check_eq("t1 wide datB", b_w, 16'hBEEF);
            tick();
        end

        // Writes, next-cycle read, bypass vs stored contents.
        cyc(1'b1, 4'd2, 16'h003C, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0);
        cyc(1'b1, 4'd0, 16'h0011, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0);
        drive_chk(1'b0, 4'd0, 16'h0, 4'd2, 4'd0, 1'b0, 4'd0, 4'd0);
        check_eq("t2 r2", {8'h0, a_b}, 16'h003C);
        check_eq("t2 dat0", {8'h0, z_b}, 16'h0011);
        tick();
        drive_chk(1'b1, 4'd2, 16'h0077, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0);
        check_eq("t2 bypass", {8'h0, a_b}, 16'h0077);
        check_eq("t2 no-bypass", {8'h0, a_n}, 16'h003C);
        tick();

        // Swap r1/r3 with mid-swap visibility.
        cyc(1'b1, 4'd1, 16'h0012, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b1, 4'd3, 16'h0034, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 4'd1, 4'd3, 1'b1, 4'd1, 4'd3);
        drive_chk(1'b0, 4'd0, 16'h0, 4'd1, 4'd3, 1'b0, 4'd0, 4'd0);
        check_eq("t3 busy", {15'h0, busy_b}, 16'h1);
        check_eq("t3 mid r1", {8'h0, a_b}, 16'h0034);
        check_eq("t3 mid r3", {8'h0, b_b}, 16'h0034);
        tick();
        drive_chk(1'b0, 4'd0, 16'h0, 4'd1, 4'd3, 1'b0, 4'd0, 4'd0);
        check_eq("t3 r1", {8'h0, a_b}, 16'h0034);
        check_eq("t3 r3", {8'h0, b_b}, 16'h0012);
        check_eq("t3 idle", {15'h0, busy_b}, 16'h0);
        tick();

        // Collisions: write with swap, then write plus swap during SWAP2.
        drive_chk(1'b1, 4'd0, 16'h00FF, 4'd0, 4'd1, 1'b1, 4'd1, 4'd3);
        check_eq("t4 drop idle", {15'h0, drop_b}, 16'h1);
        tick();
        drive_chk(1'b1, 4'd0, 16'h00EE, 4'd0, 4'd1, 1'b1, 4'd0, 4'd1);
        check_eq("t4 drop swap2", {15'h0, drop_b}, 16'h1);
        tick();
        drive_chk(1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0);
        check_eq("t4 r0", {8'h0, a_b}, 16'h0011);
        check_eq("t4 r1", {8'h0, b_b}, 16'h0012);
        check_eq("t4 no 2nd swap", {15'h0, busy_b}, 16'h0);
        tick();

        // Self-swap.
        cyc(1'b1, 4'd2, 16'h005A, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b1, 4'd2, 4'd2);
        drive_chk(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0);
        check_eq("t5 busy", {15'h0, busy_b}, 16'h1);
        check_eq("t5 mid", {8'h0, a_b}, 16'h005A);
        tick();
        drive_chk(1'b0, 4'd0, 16'h0, 4'd2, 4'd2, 1'b0, 4'd0, 4'd0);
        check_eq("t5 r2", {8'h0, a_b}, 16'h005A);
        tick();

        // Asynchronous reset in the middle of a swap.
        cyc(1'b0, 4'd0, 16'h0, 4'd1, 4'd3, 1'b1, 4'd1, 4'd3);
        drive_chk(1'b0, 4'd0, 16'h0, 4'd1, 4'd3, 1'b0, 4'd0, 4'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("t6 busy falls", {15'h0, busy_b}, 16'h0);
        check_eq("t6 r1", {8'h0, a_b}, 16'h00A5);
        check_eq("t6 r3", {8'h0, b_b}, 16'h00A5);
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        tick();

        // Wide build: addresses 15 and 0.
        cyc(1'b1, 4'd15, 16'h3C3C, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b1, 4'd0, 16'h1111, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        drive_chk(1'b1, 4'd15, 16'h7777, 4'd15, 4'd0, 1'b0, 4'd0, 4'd0);
        check_eq("t6w bypass", a_w, 16'h7777);
        check_eq("t6w dat0", z_w, 16'h1111);
        tick();
        cyc(1'b1, 4'd0, 16'h0012, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b1, 4'd15, 16'h0034, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 4'd0, 16'h0, 4'd0, 4'd15, 1'b1, 4'd0, 4'd15);
        drive_chk(1'b0, 4'd0, 16'h0, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0);
        check_eq("t6w mid r0", a_w, 16'h0034);
        check_eq("t6w mid r15", b_w, 16'h0034);
        check_eq("t6w busy", {15'h0, busy_w}, 16'h1);
        tick();
        drive_chk(1'b0, 4'd0, 16'h0, 4'd0, 4'd15, 1'b0, 4'd0, 4'd0);
        check_eq("t6w r0", a_w, 16'h0034);
        check_eq("t6w r15", b_w, 16'h0012);
        tick();

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  r_wa, r_ra, r_rb, r_sa, r_sb;
            logic [15:0] r_d;
            bit          r_we, r_sr;
            r_we = 1'($urandom_range(0, 1));
            r_sr = ($urandom_range(0, 3) == 0);
            r_wa = 4'($urandom);
            r_d  = 16'($urandom);
            r_ra = ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom);
            r_rb = ($urandom_range(0, 2) == 0) ? r_wa : 4'($urandom);
            r_sa = 4'($urandom);
            r_sb = ($urandom_range(0, 5) == 0) ? r_sa : 4'($urandom);
            drive_chk(r_we, r_wa, r_d, r_ra, r_rb, r_sr, r_sa, r_sb);
            if ($urandom_range(0, 59) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
